// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and helpers for the truth-table sweep controller.
// Optional feature macro used by this slice: TT_SWEEP_ERRLOG_EN (first-error logging).
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

   localparam int N_IN_DEFAULT = 3;

   // Number of input vectors for an n-input function.
   function automatic int nvec(input int n);
      return 32'sd1 << n;
   endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// tt_sweep_ctrl_if: stimulus/capture bundle between the sweep controller (master)
// and the environment holding the function block (slave).
// TT_SWEEP_ERRLOG_EN adds err_valid/err_idx to the bundle.
interface tt_sweep_ctrl_if
   import tt_sweep_pkg::*;
   #(parameter int N_IN = N_IN_DEFAULT)
   ();

   localparam int NVEC = nvec(N_IN);

   logic              start;
   logic [NVEC-1:0]   expected;
   logic              F;
   logic [N_IN-1:0]   vec;
   logic              busy;
   logic              done;
   logic [NVEC-1:0]   table_out;
   logic              pass;
`ifdef TT_SWEEP_ERRLOG_EN
   logic              err_valid;
   logic [N_IN-1:0]   err_idx;

   modport master (
      input  start, expected, F,
      output vec, busy, done, table_out, pass, err_valid, err_idx
   );

   modport slave (
      output start, expected, F,
      input  vec, busy, done, table_out, pass, err_valid, err_idx
   );
`else
   modport master (
      input  start, expected, F,
      output vec, busy, done, table_out, pass
   );

   modport slave (
      output start, expected, F,
      input  vec, busy, done, table_out, pass
   );
`endif

endinterface

// File: rtl/tt_dwell_cnt.sv
// tt_dwell_cnt: counts the cycles a vector has been held; last flags the
// final cycle of the dwell, where the function output is sampled.
module tt_dwell_cnt #(
   parameter int DWELL = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int             CW       = $clog2(DWELL + 1);
   localparam logic [CW-1:0]  LAST_CNT = CW'(DWELL - 1);

   logic [CW-1:0] cnt_r;

   // Dwell counter: wraps to zero after the final dwell cycle so the next vector starts clean.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         if (cnt_r == LAST_CNT) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign last = (cnt_r == LAST_CNT);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: steps a combinational block through every input vector,
// holds each for DWELL cycles, captures F on the last dwell cycle and
// compares the captured truth table with the expected one latched at start.
// Defining TT_SWEEP_ERRLOG_EN adds a first-mismatch logger (err_valid/err_idx).
module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter int N_IN  = N_IN_DEFAULT,
   parameter int DWELL = 100
) (
   input  logic               clk,
   input  logic               rst,
   tt_sweep_ctrl_if.master    bus
);

   localparam int              NVEC     = nvec(N_IN);
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

   localparam logic [1:0] S_IDLE = 2'(IDLE);
   localparam logic [1:0] S_RUN  = 2'(RUN);
   localparam logic [1:0] S_DONE = 2'(DONE);

   logic [1:0]       state_r;
   logic [N_IN-1:0]  vec_r;
   logic             busy_r;
   logic             done_r;
   logic [NVEC-1:0]  table_r;
   logic             pass_r;
   logic [NVEC-1:0]  expected_r;

   logic             last_s;
   logic             cnt_clr_s;
   logic             cnt_en_s;
   logic             sample_s;
   logic [NVEC-1:0]  sample_table_s;

   // The dwell counter only runs in RUN; in every other state it is parked at zero.
   assign cnt_en_s  = (state_r == S_RUN);
   assign cnt_clr_s = (state_r != S_RUN);
   assign sample_s  = (state_r == S_RUN) && last_s;

   tt_dwell_cnt #(
      .DWELL (DWELL)
   ) u_dwell_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr_s),
      .en   (cnt_en_s),
      .last (last_s)
   );

   // Table as it will look once the current F is captured; lets pass be
   // produced in the same cycle as done, including the final vector.
   always_comb begin
      sample_table_s         = table_r;
      sample_table_s[vec_r]  = bus.F;
   end

   // Sweep FSM with vector register, capture and verdict; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         vec_r      <= {N_IN{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         table_r    <= {NVEC{1'b0}};
         pass_r     <= 1'b0;
         expected_r <= {NVEC{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               done_r <= 1'b0;
               vec_r  <= {N_IN{1'b0}};
               if (bus.start) begin
                  expected_r <= bus.expected;
                  table_r    <= {NVEC{1'b0}};
                  pass_r     <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= S_RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_RUN: begin
               done_r <= 1'b0;
               if (sample_s) begin
                  table_r <= sample_table_s;
                  if (vec_r == LAST_VEC) begin
                     // Final vector: vec holds, verdict and done appear together.
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                     pass_r  <= (sample_table_s == expected_r);
                     state_r <= S_DONE;
                  end else begin
                     vec_r   <= vec_r + N_IN'(1);
                     state_r <= S_RUN;
                  end
               end else begin
                  state_r <= S_RUN;
               end
            end
            S_DONE: begin
               // start is deliberately ignored here; a held start launches from IDLE.
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               vec_r   <= {N_IN{1'b0}};
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
               vec_r   <= {N_IN{1'b0}};
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.vec       = vec_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.table_out = table_r;
   assign bus.pass      = pass_r;

`ifdef TT_SWEEP_ERRLOG_EN
   logic             err_valid_r;
   logic [N_IN-1:0]  err_idx_r;

   // First-mismatch logger: records the lowest vector whose F disagrees with the expectation.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_valid_r <= 1'b0;
         err_idx_r   <= {N_IN{1'b0}};
      end else if ((state_r == S_IDLE) && bus.start) begin
         err_valid_r <= 1'b0;
         err_idx_r   <= {N_IN{1'b0}};
      end else if (sample_s && (bus.F != expected_r[vec_r]) && !err_valid_r) begin
         err_valid_r <= 1'b1;
         err_idx_r   <= vec_r;
      end else begin
         err_valid_r <= err_valid_r;
         err_idx_r   <= err_idx_r;
      end
   end

   assign bus.err_valid = err_valid_r;
   assign bus.err_idx   = err_idx_r;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: directed, table-driven bench for tt_sweep_ctrl.
// Instance A uses DWELL=4, instance B uses DWELL=1; both N_IN=3.
module tb_tt_sweep_ctrl;

   localparam int DWELL_A = 4;
   localparam int DWELL_B = 1;

   logic clk;
   logic rst;
   logic [1:0] f_mode;

   int n_cmp;
   int n_err;

   tt_sweep_ctrl_if #(.N_IN(3)) bus_a ();
   tt_sweep_ctrl_if #(.N_IN(3)) bus_b ();

   tt_sweep_ctrl #(.N_IN(3), .DWELL(DWELL_A)) u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.master)
   );

   tt_sweep_ctrl #(.N_IN(3), .DWELL(DWELL_B)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.master)
   );

   // Clock generation, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Function block models: vec[2]=A, vec[1]=B, vec[0]=C.
   always_comb begin
      case (f_mode)
         2'd0:    bus_a.F = bus_a.vec[2] ^ bus_a.vec[1] ^ bus_a.vec[0];
         2'd1:    bus_a.F = bus_a.vec[2] & bus_a.vec[1] & bus_a.vec[0];
         2'd2:    bus_a.F = 1'b1;
         2'd3:    bus_a.F = bus_a.vec[2];
         default: bus_a.F = 1'b0;
      endcase
   end

   // Instance B always sees the XOR function.
   always_comb begin
      bus_b.F = bus_b.vec[2] ^ bus_b.vec[1] ^ bus_b.vec[0];
   end

   typedef struct {
      logic [1:0] mode;
      logic [7:0] exp_in;
      logic [7:0] tbl;
      logic       pass;
      logic       err_v;
      logic [2:0] err_idx;
   } vec_rec_t;

   vec_rec_t recs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One full sweep on instance A driven from a table record.
   task automatic run_sweep(input vec_rec_t r);
      int cyc;
      bit seen;
      @(negedge clk);
      f_mode         = r.mode;
      bus_a.expected = r.exp_in;
      bus_a.start    = 1'b1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         bus_a.start    = 1'b0;
         bus_a.expected = ~r.exp_in;
         if (bus_a.done) begin
            seen = 1'b1;
         end else begin
            check("vec_step", 32'(bus_a.vec), 32'((cyc - 1) / DWELL_A));
            check("busy_run", 32'(bus_a.busy), 32'd1);
         end
      end
      check("done_latency", 32'(cyc), 32'd33);
      check("busy_done", 32'(bus_a.busy), 32'd0);
      check("table_out", 32'(bus_a.table_out), 32'(r.tbl));
      check("pass", 32'(bus_a.pass), 32'(r.pass));
`ifdef TT_SWEEP_ERRLOG_EN
      check("err_valid", 32'(bus_a.err_valid), 32'(r.err_v));
      if (r.err_v) begin
         check("err_idx", 32'(bus_a.err_idx), 32'(r.err_idx));
      end
`endif
      @(posedge clk);
      @(negedge clk);
      check("done_pulse_end", 32'(bus_a.done), 32'd0);
      check("vec_idle", 32'(bus_a.vec), 32'd0);
      check("pass_held", 32'(bus_a.pass), 32'(r.pass));
      check("table_held", 32'(bus_a.table_out), 32'(r.tbl));
   endtask

   initial begin
      int cyc;
      int ndone;
      int first_done;

      n_cmp          = 0;
      n_err          = 0;
      f_mode         = 2'd0;
      rst            = 1'b1;
      bus_a.start    = 1'b0;
      bus_a.expected = 8'h00;
      bus_b.start    = 1'b0;
      bus_b.expected = 8'h00;

      recs[0] = '{mode: 2'd0, exp_in: 8'h96, tbl: 8'h96, pass: 1'b1, err_v: 1'b0, err_idx: 3'd0};
      recs[1] = '{mode: 2'd1, exp_in: 8'h96, tbl: 8'h80, pass: 1'b0, err_v: 1'b1, err_idx: 3'd1};
      recs[2] = '{mode: 2'd0, exp_in: 8'h97, tbl: 8'h96, pass: 1'b0, err_v: 1'b1, err_idx: 3'd0};
      recs[3] = '{mode: 2'd1, exp_in: 8'h80, tbl: 8'h80, pass: 1'b1, err_v: 1'b0, err_idx: 3'd0};
      recs[4] = '{mode: 2'd2, exp_in: 8'hFF, tbl: 8'hFF, pass: 1'b1, err_v: 1'b0, err_idx: 3'd0};
      recs[5] = '{mode: 2'd3, exp_in: 8'hF1, tbl: 8'hF0, pass: 1'b0, err_v: 1'b1, err_idx: 3'd0};
      recs[6] = '{mode: 2'd3, exp_in: 8'hB0, tbl: 8'hF0, pass: 1'b0, err_v: 1'b1, err_idx: 3'd6};

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_vec", 32'(bus_a.vec), 32'd0);
      check("rst_busy", 32'(bus_a.busy), 32'd0);
      check("rst_done", 32'(bus_a.done), 32'd0);
      check("rst_table", 32'(bus_a.table_out), 32'd0);
      check("rst_pass", 32'(bus_a.pass), 32'd0);
      check("rst_b_table", 32'(bus_b.table_out), 32'd0);
      rst = 1'b0;

      // Table-driven sweeps.
      for (int i = 0; i < 7; i++) begin
         run_sweep(recs[i]);
      end

      // Restart attempt mid-sweep at vec=3 must be ignored.
      @(negedge clk);
      f_mode         = 2'd0;
      bus_a.expected = 8'h96;
      bus_a.start    = 1'b1;
      ndone      = 0;
      first_done = 0;
      for (cyc = 1; cyc <= 60; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         bus_a.start = (cyc == 13);
         if (cyc == 13) begin
            check("restart_at_vec3", 32'(bus_a.vec), 32'd3);
         end
         if (bus_a.done) begin
            ndone++;
            if (first_done == 0) begin
               first_done = cyc;
            end
         end
      end
      bus_a.start = 1'b0;
      check("restart_done_latency", 32'(first_done), 32'd33);
      check("restart_single_done", 32'(ndone), 32'd1);
      check("restart_table", 32'(bus_a.table_out), 32'h96);

      // Reset while vec=5: everything clears, no done pulse follows.
      @(negedge clk);
      bus_a.expected = 8'h96;
      bus_a.start    = 1'b1;
      for (cyc = 1; cyc <= 21; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         bus_a.start = 1'b0;
      end
      check("pre_rst_vec5", 32'(bus_a.vec), 32'd5);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_vec", 32'(bus_a.vec), 32'd0);
      check("midrst_busy", 32'(bus_a.busy), 32'd0);
      check("midrst_table", 32'(bus_a.table_out), 32'd0);
      check("midrst_done", 32'(bus_a.done), 32'd0);
      ndone = 0;
      for (cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus_a.done) begin
            ndone++;
         end
      end
      check("midrst_no_done", 32'(ndone), 32'd0);

      // DWELL=1 instance: vec advances every cycle, done 9 cycles after start.
      @(negedge clk);
      bus_b.expected = 8'h96;
      bus_b.start    = 1'b1;
      cyc        = 0;
      first_done = 0;
      while (first_done == 0 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         bus_b.start = 1'b0;
         if (bus_b.done) begin
            first_done = cyc;
         end else begin
            check("d1_vec_step", 32'(bus_b.vec), 32'(cyc - 1));
         end
      end
      check("d1_done_latency", 32'(cyc), 32'd9);
      check("d1_table", 32'(bus_b.table_out), 32'h96);
      check("d1_pass", 32'(bus_b.pass), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
